ws2812_frame_tx: RTL and testbench

Serves the frame requests produced by the frame-rate prescaler and drives the addressable LED strip data line.
- On each frame_start pulse it fetches one 24-bit GRB word per LED from the pattern logic through a request/valid handshake.
- It serialises each word MSB first as WS2812 NRZ pulses.
- It ends the frame with the latch (reset) low time.
- It sits between the frame/pattern generator and the strip data pin.

---
 rtl/ws2812_pkg.sv | 28 ++
 rtl/ws2812_bit_encoder.sv | 44 ++++
 rtl/ws2812_frame_tx.sv | 184 ++++++++++++++++++
 tb/tb_ws2812_frame_tx.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ws2812_pkg.sv
// Shared WS2812 timing defaults, cycle conversion, FSM state type and GRB layout.
package ws2812_pkg;

  localparam int CLK_PERIOD_NS_DEF = 20;
  localparam int LED_COUNT_DEF     = 8;
  localparam int T0H_NS_DEF        = 400;
  localparam int T1H_NS_DEF        = 800;
  localparam int TBIT_NS_DEF       = 1250;
  localparam int TRST_NS_DEF       = 50000;

  localparam int WORD_W     = 24;
  localparam int BIT_CNT_W  = 5;
  localparam int TBIT_CNT_W = 8;
  localparam int TRST_CNT_W = 16;

  // GRB word layout: G[23:16] R[15:8] B[7:0]
  localparam int G_LSB = 16;
  localparam int R_LSB = 8;
  localparam int B_LSB = 0;

  typedef enum logic [1:0] {IDLE, FETCH, SEND, LATCH} state_t;

  // Floored conversion from a duration in ns to whole clock cycles.
  function automatic int ns_to_cycles(input int ns, input int clk_period_ns);
    return ns / clk_period_ns;
  endfunction

endpackage

// File: rtl/ws2812_bit_encoder.sv
// Emits one WS2812 NRZ bit per start strobe; bit_done marks the last cycle of the
// bit period so a following start continues with no gap.
module ws2812_bit_encoder
  import ws2812_pkg::*;
#(
  parameter int T0H  = 20,
  parameter int T1H  = 40,
  parameter int TBIT = 62
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic bit_in,
  output logic dout,
  output logic bit_done
);

  localparam logic [TBIT_CNT_W-1:0] T0H_C  = TBIT_CNT_W'(T0H);
  localparam logic [TBIT_CNT_W-1:0] T1H_C  = TBIT_CNT_W'(T1H);
  localparam logic [TBIT_CNT_W-1:0] LAST_C = TBIT_CNT_W'(TBIT - 1);

  logic                  active;
  logic                  bit_val;
  logic [TBIT_CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      active  <= 1'b0;
      bit_val <= 1'b0;
      cnt     <= '0;
    end else if (start) begin
      active  <= 1'b1;
      bit_val <= bit_in;
      cnt     <= '0;
    end else if (active) begin
      if (cnt == LAST_C) active <= 1'b0;
      else               cnt    <= cnt + TBIT_CNT_W'(1);
    end
  end

  assign bit_done = active && (cnt == LAST_C);
  assign dout     = active && (cnt < (bit_val ? T1H_C : T0H_C));

endmodule

// File: rtl/ws2812_frame_tx.sv
// Frame transmitter: fetches one GRB word per LED with one-word prefetch,
// serialises MSB first through the bit encoder, then holds the latch low time.
module ws2812_frame_tx
  import ws2812_pkg::*;
#(
  parameter int CLK_PERIOD_NS = CLK_PERIOD_NS_DEF,
  parameter int LED_COUNT     = LED_COUNT_DEF,
  parameter int T0H_NS        = T0H_NS_DEF,
  parameter int T1H_NS        = T1H_NS_DEF,
  parameter int TBIT_NS       = TBIT_NS_DEF,
  parameter int TRST_NS       = TRST_NS_DEF,
  localparam int LED_W        = (LED_COUNT > 1) ? $clog2(LED_COUNT) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              frame_start,
  output logic              pixel_rqst,
  output logic [LED_W-1:0]  led_no,
  input  logic [WORD_W-1:0] pixel_data,
  input  logic              pixel_valid,
  output logic              dout,
  output logic              busy,
  output logic              frame_done,
  output logic              underrun
);

  localparam int T0H_CYC  = ns_to_cycles(T0H_NS, CLK_PERIOD_NS);
  localparam int T1H_CYC  = ns_to_cycles(T1H_NS, CLK_PERIOD_NS);
  localparam int TBIT_CYC = ns_to_cycles(TBIT_NS, CLK_PERIOD_NS);
  localparam int TRST_CYC = ns_to_cycles(TRST_NS, CLK_PERIOD_NS);

  localparam logic [LED_W-1:0]      LAST_LED  = LED_W'(LED_COUNT - 1);
  localparam logic [TRST_CNT_W-1:0] TRST_LAST = TRST_CNT_W'(TRST_CYC - 1);

  state_t                state, state_nx;
  logic [WORD_W-2:0]     shift;
  logic [WORD_W-1:0]     nxt_buf, nxt_word;
  logic                  nxt_full, pend;
  logic [BIT_CNT_W-1:0]  bit_cnt;
  logic [LED_W-1:0]      cur_led;
  logic [TRST_CNT_W-1:0] rst_cnt;
  logic                  enc_start, enc_bit, bit_done;
  logic                  fetch_cap, pre_cap, last_word, avail, swap, step;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    enc_start = 1'b0;
    enc_bit   = 1'b0;
    fetch_cap = (state == FETCH) && pixel_rqst && pixel_valid;
    pre_cap   = (state == SEND) && pixel_rqst && pixel_valid;
    last_word = (cur_led == LAST_LED);
    // A prefetch answered in the word-boundary cycle itself still counts as ready.
    avail     = nxt_full || pre_cap;
    nxt_word  = nxt_full ? nxt_buf : pixel_data;
    swap      = 1'b0;
    step      = 1'b0;
    case (state)
      IDLE:  if (frame_start && !frame_done) state_nx = FETCH;
      FETCH: if (fetch_cap) begin
        state_nx  = SEND;
        enc_start = 1'b1;
        enc_bit   = pixel_data[WORD_W-1];
      end
      SEND: if (bit_done) begin
        if (bit_cnt != '0) begin
          step      = 1'b1;
          enc_start = 1'b1;
          enc_bit   = shift[WORD_W-2];
        end else if (last_word) begin
          state_nx = LATCH;
        end else if (avail) begin
          swap      = 1'b1;
          enc_start = 1'b1;
          enc_bit   = nxt_word[WORD_W-1];
        end else begin
          state_nx = FETCH;
        end
      end
      LATCH: if (rst_cnt == TRST_LAST) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      busy       <= 1'b0;
      pixel_rqst <= 1'b0;
      led_no     <= '0;
      frame_done <= 1'b0;
      underrun   <= 1'b0;
      nxt_full   <= 1'b0;
      pend       <= 1'b0;
      cur_led    <= '0;
      bit_cnt    <= '0;
      rst_cnt    <= '0;
    end else begin
      frame_done <= 1'b0;
      // A prefetch request goes up one cycle after the previous request dropped.
      if (pend && !pixel_rqst) begin
        pixel_rqst <= 1'b1;
        pend       <= 1'b0;
      end
      if (pre_cap) begin
        nxt_full   <= 1'b1;
        pixel_rqst <= 1'b0;
      end
      case (state)
        IDLE: if (frame_start && !frame_done) begin
          busy       <= 1'b1;
          led_no     <= '0;
          cur_led    <= '0;
          underrun   <= 1'b0;
          pixel_rqst <= 1'b1;
          nxt_full   <= 1'b0;
          pend       <= 1'b0;
        end
        FETCH: if (fetch_cap) begin
          pixel_rqst <= 1'b0;
          bit_cnt    <= BIT_CNT_W'(WORD_W - 1);
          if (!last_word) begin
            led_no <= cur_led + LED_W'(1);
            pend   <= 1'b1;
          end
        end
        SEND: if (bit_done) begin
          if (step) begin
            bit_cnt <= bit_cnt - BIT_CNT_W'(1);
          end else if (last_word) begin
            rst_cnt <= '0;
          end else if (swap) begin
            cur_led    <= cur_led + LED_W'(1);
            bit_cnt    <= BIT_CNT_W'(WORD_W - 1);
            nxt_full   <= 1'b0;
            pixel_rqst <= 1'b0;
            if (int'(cur_led) + 2 < LED_COUNT) begin
              led_no <= cur_led + LED_W'(2);
              pend   <= 1'b1;
            end
          end else begin
            cur_led    <= cur_led + LED_W'(1);
            underrun   <= 1'b1;
            pixel_rqst <= 1'b1;
            pend       <= 1'b0;
          end
        end
        LATCH: begin
          if (rst_cnt == TRST_LAST) begin
            frame_done <= 1'b1;
            busy       <= 1'b0;
          end else begin
            rst_cnt <= rst_cnt + TRST_CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (fetch_cap)  shift <= pixel_data[WORD_W-2:0];
    else if (swap)  shift <= nxt_word[WORD_W-2:0];
    else if (step)  shift <= {shift[WORD_W-3:0], 1'b0};
    if (pre_cap) nxt_buf <= pixel_data;
  end

  ws2812_bit_encoder #(
    .T0H  (T0H_CYC),
    .T1H  (T1H_CYC),
    .TBIT (TBIT_CYC)
  ) u_enc (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (enc_start),
    .bit_in   (enc_bit),
    .dout     (dout),
    .bit_done (bit_done)
  );

endmodule

// File: tb/tb_ws2812_frame_tx.sv
// Bench for ws2812_frame_tx: frames decoded from dout and compared against the
// bit stream implied by the supplied pixel words and the WS2812 timing rules.
module tb_ws2812_frame_tx;

  localparam int NLED   = 8;
  localparam int NBITS  = NLED * 24;
  localparam int T0H_C  = 20;
  localparam int T1H_C  = 40;
  localparam int TBIT_C = 62;
  localparam int TRST_C = 2500;

  logic        clk = 1'b0;
  logic        rst_n, frame_start, pixel_valid;
  logic [23:0] pixel_data;
  logic        pixel_rqst, dout, busy, frame_done, underrun;
  logic [2:0]  led_no;

  logic        rst2_n, frame_start2, pixel_valid2;
  logic [23:0] pixel_data2;
  logic        pixel_rqst2, dout2, busy2, frame_done2, underrun2;
  logic [2:0]  led_no2;

  always #5 clk = ~clk;

  ws2812_frame_tx dut (
    .clk(clk), .rst_n(rst_n), .frame_start(frame_start), .pixel_rqst(pixel_rqst),
    .led_no(led_no), .pixel_data(pixel_data), .pixel_valid(pixel_valid),
    .dout(dout), .busy(busy), .frame_done(frame_done), .underrun(underrun)
  );

  ws2812_frame_tx #(.CLK_PERIOD_NS(10)) dut10 (
    .clk(clk), .rst_n(rst2_n), .frame_start(frame_start2), .pixel_rqst(pixel_rqst2),
    .led_no(led_no2), .pixel_data(pixel_data2), .pixel_valid(pixel_valid2),
    .dout(dout2), .busy(busy2), .frame_done(frame_done2), .underrun(underrun2)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d want=%0d", name, act, exp);
    end
  endtask

  int          cyc = 0;
  logic [23:0] pix [NLED];
  int          dly [NLED];
  int          cap [NLED];
  int          exp_led;
  int          rise_q[$];
  int          hi_q[$];
  bit          dut10_done = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // Pixel source: answers each request after dly[led] cycles, checking request order and stability.
  initial begin
    int   wcnt;
    logic [2:0] seen;
    wcnt = 0; seen = '0;
    pixel_valid = 1'b0;
    pixel_data  = '0;
    forever begin
      @(negedge clk);
      if (pixel_valid) begin
        pixel_valid = 1'b0;
        wcnt = 0;
      end else if (pixel_rqst) begin
        if (wcnt == 0) seen = led_no;
        if (wcnt >= dly[led_no]) begin
          chk("led_stable", 32'(led_no), 32'(seen));
          chk("led_order", 32'(led_no), exp_led);
          exp_led++;
          pixel_data  = pix[led_no];
          pixel_valid = 1'b1;
          cap[led_no] = cyc;
          wcnt = 0;
        end else begin
          wcnt++;
        end
      end else begin
        wcnt = 0;
      end
    end
  end

  // dout decoder: one entry per high pulse (rise cycle, high length).
  initial begin
    logic prev;
    int   hcnt, rcyc;
    prev = 1'b0; hcnt = 0; rcyc = 0;
    forever begin
      @(negedge clk);
      if (dout && !prev) begin
        rcyc = cyc;
        hcnt = 1;
      end else if (dout) begin
        hcnt++;
      end else if (prev) begin
        rise_q.push_back(rcyc);
        hi_q.push_back(hcnt);
      end
      prev = dout;
    end
  end

  // 10 ns clock instance: answer at once with alternating bits and measure the first pulses.
  initial begin
    pixel_valid2 = 1'b0;
    pixel_data2  = 24'hAAAAAA;
    forever begin
      @(negedge clk);
      pixel_valid2 = pixel_rqst2 && !pixel_valid2;
    end
  end

  initial begin
    int   r2 [4];
    int   h2 [4];
    int   n, hc;
    logic pv;
    n = 0; hc = 0; pv = 1'b0;
    rst2_n = 1'b0;
    frame_start2 = 1'b0;
    repeat (3) @(negedge clk);
    rst2_n = 1'b1;
    @(negedge clk) frame_start2 = 1'b1;
    @(negedge clk) frame_start2 = 1'b0;
    for (int i = 0; i < 3000 && n < 4; i++) begin
      @(negedge clk);
      if (dout2 && !pv) begin r2[n] = cyc; hc = 1; end
      else if (dout2) hc++;
      else if (pv) begin h2[n] = hc; n++; end
      pv = dout2;
    end
    chk("clk10_pulses", n, 4);
    if (n == 4) begin
      chk("clk10_t1h_a", h2[0], 80);
      chk("clk10_t0h_a", h2[1], 40);
      chk("clk10_t1h_b", h2[2], 80);
      chk("clk10_t0h_b", h2[3], 40);
      for (int i = 1; i < 4; i++) chk("clk10_tbit", r2[i] - r2[i-1], 125);
    end
    dut10_done = 1'b1;
  end

  typedef struct {
    int pat;     // 0: all zero, 1: LED0=0x800001 rest zero, 2: random words and delays
    int d3;      // response delay for LED3
    bit inject;  // pulse frame_start mid-frame and in the frame_done cycle
    bit exp_ur;  // underrun expected at frame end
  } frame_vec_t;

  frame_vec_t vecs [4];

  initial begin
    int  t0, dc, nb, np, gap;
    bit  timeout, found;
    vecs[0] = '{pat: 0, d3: 1,    inject: 1'b0, exp_ur: 1'b0};
    vecs[1] = '{pat: 1, d3: 200,  inject: 1'b0, exp_ur: 1'b0};
    vecs[2] = '{pat: 2, d3: 2000, inject: 1'b1, exp_ur: 1'b1};
    vecs[3] = '{pat: 2, d3: 1,    inject: 1'b0, exp_ur: 1'b0};

    for (int k = 0; k < NLED; k++) begin pix[k] = '0; dly[k] = 1; cap[k] = 0; end
    exp_led = 0;
    rst_n = 1'b0;
    frame_start = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_dout", 32'(dout), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_rqst", 32'(pixel_rqst), 0);
    chk("rst_led_no", 32'(led_no), 0);
    chk("rst_frame_done", 32'(frame_done), 0);
    chk("rst_underrun", 32'(underrun), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Abort a frame with a one-cycle reset while dout is high.
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
    t0 = cyc;
    found = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (dout && (cyc - t0) > 150) begin found = 1'b1; break; end
    end
    chk("abort_dout_seen", 32'(found), 1);
    rst_n = 1'b0;
    @(negedge clk);
    chk("abort_dout", 32'(dout), 0);
    chk("abort_busy", 32'(busy), 0);
    chk("abort_rqst", 32'(pixel_rqst), 0);
    chk("abort_led_no", 32'(led_no), 0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    for (int v = 0; v < 4; v++) begin
      for (int k = 0; k < NLED; k++) begin
        case (vecs[v].pat)
          0:       pix[k] = '0;
          1:       pix[k] = (k == 0) ? 24'h800001 : 24'h000000;
          default: pix[k] = 24'($urandom);
        endcase
        dly[k] = (vecs[v].pat == 2) ? int'($urandom_range(0, 6)) : 1;
      end
      dly[3] = vecs[v].d3;
      if (v > 0) chk("underrun_sticky", 32'(underrun), 32'(vecs[v-1].exp_ur));
      rise_q.delete();
      hi_q.delete();
      exp_led = 0;
      @(negedge clk) frame_start = 1'b1;
      @(negedge clk) frame_start = 1'b0;
      chk("accept_busy", 32'(busy), 1);
      chk("accept_underrun_clr", 32'(underrun), 0);
      t0 = cyc;
      dc = 0;
      timeout = 1'b1;
      for (int i = 0; i < 40000; i++) begin
        @(negedge clk);
        frame_start = vecs[v].inject && ((cyc - t0) == 3000);
        if (vecs[v].inject && (cyc - t0) == 3001) chk("busy_mid_start", 32'(busy), 1);
        if (frame_done) begin
          frame_start = vecs[v].inject;
          dc = cyc;
          timeout = 1'b0;
          break;
        end
      end
      chk("frame_timeout", 32'(timeout), 0);
      chk("done_busy", 32'(busy), 0);
      chk("done_underrun", 32'(underrun), 32'(vecs[v].exp_ur));
      @(negedge clk);
      frame_start = 1'b0;
      chk("idle_busy_after_done", 32'(busy), 0);
      chk("idle_rqst_after_done", 32'(pixel_rqst), 0);

      chk("pulse_count", rise_q.size(), NBITS);
      nb = 0;
      np = 0;
      for (int i = 0; i < NBITS && i < rise_q.size(); i++) begin
        if (hi_q[i] != (pix[i / 24][23 - (i % 24)] ? T1H_C : T0H_C)) begin
          if (nb == 0) $display("  pulse %0d width %0d", i, hi_q[i]);
          nb++;
        end
        if (i > 0) begin
          gap = rise_q[i] - rise_q[i-1];
          if (vecs[v].exp_ur && i == 3 * 24) begin
            if (gap <= TBIT_C) np++;
          end else if (gap != TBIT_C) begin
            np++;
          end
        end
      end
      chk("pulse_width", nb, 0);
      chk("bit_period", np, 0);
      if (rise_q.size() >= NBITS) begin
        chk("first_rise_latency", rise_q[0] - cap[0], 1);
        if (vecs[v].exp_ur) chk("resume_rise_latency", rise_q[3 * 24] - cap[3], 1);
        chk("latch_time", dc - rise_q[NBITS-1], TBIT_C + TRST_C);
      end
    end

    for (int i = 0; i < 5000 && !dut10_done; i++) @(negedge clk);
    chk("clk10_finished", 32'(dut10_done), 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
